// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronizer plus four-state debounce FSM; optional edge pulses under INPUT_DEBOUNCER_EDGE_EN
module input_debouncer #(
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  // Stable levels sit at even codes, candidate levels at odd codes.
  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  // Last count value of a qualification window; reaching it with the input
  // still at the candidate level accepts the new level.
  localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 sync1;
  logic                 sync_in;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 clean_next;
  logic                 busy_next;

`ifndef SYNTHESIS
  // Catch parameter sets whose terminal count cannot be represented.
  initial begin
    if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > (longint'(1) << CNT_WIDTH)) begin
      $error("input_debouncer: STABLE_CYCLES=%0d outside 2..2**CNT_WIDTH (CNT_WIDTH=%0d)",
             STABLE_CYCLES, CNT_WIDTH);
    end
  end
`endif

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1   <= 1'b0;
      sync_in <= 1'b0;
    end else begin
      sync1   <= noisy_in;
      sync_in <= sync1;
    end
  end

  // Next-state, counter and next-output decode; a revert always beats the
  // terminal count, so a window that is interrupted never emits anything.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE_LOW: begin
        if (sync_in) begin
          state_next = CHECK_HIGH;
          cnt_next   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sync_in) begin
          state_next = IDLE_LOW;
        end else if (cnt == TERM_CNT) begin
          state_next = IDLE_HIGH;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync_in) begin
          state_next = CHECK_LOW;
          cnt_next   = '0;
        end
      end
      CHECK_LOW: begin
        if (sync_in) begin
          state_next = IDLE_HIGH;
        end else if (cnt == TERM_CNT) begin
          state_next = IDLE_LOW;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
    clean_next = (state_next == IDLE_HIGH) || (state_next == CHECK_LOW);
    busy_next  = (state_next == CHECK_HIGH) || (state_next == CHECK_LOW);
  end

  // State, counter and level outputs all move on the same edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      clean_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      clean_out <= clean_next;
      busy      <= busy_next;
    end
  end

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic rise_next;
  logic fall_next;

  // A pulse is raised only on an accepted level change, never on a revert.
  always_comb begin
    rise_next = (state == CHECK_HIGH) && (state_next == IDLE_HIGH);
    fall_next = (state == CHECK_LOW)  && (state_next == IDLE_LOW);
  end

  // Pulse registers share the state edge, so they line up with clean_out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
    end
  end
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed-vector bench for input_debouncer with STABLE_CYCLES=4, CNT_WIDTH=3
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk;
  logic n_rst;
  logic noisy_in;
  logic clean_out;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int n_vec;
  int n_err;
  int n_rise;

  input_debouncer #(.CNT_WIDTH(3), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .noisy_in   (noisy_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold noisy_in high for len sampling edges from stable low; len <= 4 must be rejected.
  task automatic reject_test(input int len);
    noisy_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == len) noisy_in = 1'b0;
      check("rej_busy", busy, (i >= 3 && i <= len + 2));
      check("rej_clean", clean_out, 0);
      check("rej_rise", rise_pulse, 0);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_rise   = 0;
    n_rst    = 1'b0;
    noisy_in = 1'b0;
    repeat (3) tick();
    check("rst_clean", clean_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rise", rise_pulse, 0);
    check("rst_fall", fall_pulse, 0);
    n_rst = 1'b1;
    repeat (3) tick();
    check("idle_clean", clean_out, 0);
    check("idle_busy", busy, 0);

    // Clean rise: tick i is edge k+i-1.
    noisy_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("rise_busy", busy, (i >= 3 && i <= 6));
      check("rise_clean", clean_out, (i >= 7));
      check("rise_pulse", rise_pulse, (EDGE && i == 7));
      check("rise_nofall", fall_pulse, 0);
    end

    // Clean fall.
    noisy_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("fall_busy", busy, (i >= 3 && i <= 6));
      check("fall_clean", clean_out, (i <= 6));
      check("fall_pulse", fall_pulse, (EDGE && i == 7));
      check("fall_norise", rise_pulse, 0);
    end

    // Glitch of 3 cycles, then revert on the terminal-count cycle.
    reject_test(3);
    repeat (2) tick();
    reject_test(4);
    repeat (2) tick();

    // Bounce 1,0,1,0 then hold 1; final rise sampled at tick 5.
    noisy_in = 1'b1;
    n_rise   = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i <= 3) noisy_in = ~noisy_in;
      else noisy_in = 1'b1;
      if (rise_pulse) n_rise++;
      if (i == 10) check("bnc_clean_pre", clean_out, 0);
      if (i == 11) begin
        check("bnc_clean", clean_out, 1);
        check("bnc_rise", rise_pulse, EDGE);
      end
    end
    check("bnc_rise_cnt", 8'(n_rise), EDGE ? 8'd1 : 8'd0);

    // Fall interrupted by reset mid-qualification.
    noisy_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("rfl_clean", clean_out, 1);
    end
    check("rfl_busy", busy, 1);
    noisy_in = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("arst_clean", clean_out, 0);
    check("arst_busy", busy, 0);
    check("arst_rise", rise_pulse, 0);
    check("arst_fall", fall_pulse, 0);
    repeat (2) begin
      tick();
      check("inrst_fall", fall_pulse, 0);
      check("inrst_clean", clean_out, 0);
    end
    n_rst  = 1'b1;
    n_rise = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (rise_pulse) n_rise++;
      check("post_busy", busy, (i >= 3 && i <= 6));
      check("post_clean", clean_out, (i >= 7));
      check("post_rise", rise_pulse, (EDGE && i == 7));
      check("post_fall", fall_pulse, 0);
    end
    check("post_rise_cnt", 8'(n_rise), EDGE ? 8'd1 : 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
